// File: rtl/act_lut_pkg.sv
// Shared definitions for the activation-function LUT loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the table geometry (17 signed 8-bit samples addressed by a 4-bit
// segment index), the loader state encoding and the signed sample type.
package act_lut_pkg;

    localparam int LUT_DEPTH  = 17;
    localparam int LUT_ADDR_W = 4;
    localparam int SAMPLE_W   = 8;

    // Index width for the 17 entries: one more bit than the segment address
    // so that address+1 reaches the end point without wrapping.
    localparam int CNT_W = LUT_ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } lut_state_t;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/act_lut_regfile.sv
// 17x8 sample register file: one write port, two combinational read ports.
// Latency: writes land on the clock edge; reads are 0-cycle combinational.
// Backpressure: none, a write is taken whenever wr_en is high.
//
// Ports: clk/rst (async active-low, clears every entry), wr_en/wr_addr/
// wr_data write port, rd_addr segment index, rd_data0 = mem[rd_addr],
// rd_data1 = mem[rd_addr+1] (computed wide, so index 15 reads entry 16).
module act_lut_regfile
    import act_lut_pkg::*;
#(
    parameter int DEPTH = LUT_DEPTH,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [CNT_W-1:0]        wr_addr,
    input  logic signed [WIDTH-1:0] wr_data,
    input  logic [LUT_ADDR_W-1:0]   rd_addr,
    output logic signed [WIDTH-1:0] rd_data0,
    output logic signed [WIDTH-1:0] rd_data1
);

    logic signed [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0]        rd_idx0;
    logic [CNT_W-1:0]        rd_idx1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_idx0  = {1'b0, rd_addr};
    assign rd_idx1  = {1'b0, rd_addr} + CNT_W'(1);
    assign rd_data0 = mem[rd_idx0];
    assign rd_data1 = mem[rd_idx1];

endmodule

// File: rtl/act_lut_loader.sv
// Run-time loader and read port for the activation-function lookup table.
// Latency: 17 accepted words after start to loaded (18 with checksum); reads 0-cycle.
// Backpressure: in__ready is high only while a load is in progress; in__valid is ignored otherwise.
//
// Ports: clk, rst (async active-low), start (pulse, begins/aborts a load),
// in__data/in__valid/in__ready sample stream, loaded (table usable),
// error (checksum mismatch), address (segment index), base/next__data
// (mem[address], mem[address+1], both 0 while the table is not loaded).
// Optional build macro ACT_LUT_CHECKSUM_EN: after the 17 samples one extra
// word is accepted and compared with their modulo-256 sum; a mismatch
// returns to idle with error set. Without it, error is tied low.
module act_lut_loader
    import act_lut_pkg::*;
#(
    parameter int DEPTH = LUT_DEPTH,
    parameter int WIDTH = SAMPLE_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] in__data,
    input  logic                    in__valid,
    output logic                    in__ready,
    output logic                    loaded,
    output logic                    error,
    input  logic [LUT_ADDR_W-1:0]   address,
    output logic signed [WIDTH-1:0] base,
    output logic signed [WIDTH-1:0] next__data
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    lut_state_t              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    ready_q;
    logic                    loaded_q;
    logic                    hs;
    logic                    wr_en;
    logic signed [WIDTH-1:0] rd_base;
    logic signed [WIDTH-1:0] rd_next;

`ifdef ACT_LUT_CHECKSUM_EN
    logic signed [WIDTH-1:0] sum_q;
    logic                    error_q;
`endif

    assign hs = in__valid && ready_q;
    // start wins over a same-cycle handshake: that word is dropped.
    assign wr_en = hs && !start && (state_q == ST_LOAD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b0;
            loaded_q <= 1'b0;
`ifdef ACT_LUT_CHECKSUM_EN
            sum_q    <= '0;
            error_q  <= 1'b0;
`endif
        end else if (start) begin
            // Begin or abort-and-restart from any state.
            state_q  <= ST_LOAD;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            loaded_q <= 1'b0;
`ifdef ACT_LUT_CHECKSUM_EN
            sum_q    <= '0;
            error_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (hs) begin
                        cnt_q <= cnt_q + CNT_W'(1);
`ifdef ACT_LUT_CHECKSUM_EN
                        sum_q <= sum_q + in__data;
`endif
                        if (cnt_q == LAST_IDX) begin
`ifdef ACT_LUT_CHECKSUM_EN
                            // Stay ready: the checksum word follows.
                            state_q <= ST_CHECK;
`else
                            state_q  <= ST_DONE;
                            ready_q  <= 1'b0;
                            loaded_q <= 1'b1;
`endif
                        end
                    end
                end
`ifdef ACT_LUT_CHECKSUM_EN
                ST_CHECK: begin
                    if (hs) begin
                        ready_q <= 1'b0;
                        if (in__data == sum_q) begin
                            state_q  <= ST_DONE;
                            loaded_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            error_q <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    // IDLE and DONE hold until the next start.
                end
            endcase
        end
    end

    act_lut_regfile #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (cnt_q),
        .wr_data  (in__data),
        .rd_addr  (address),
        .rd_data0 (rd_base),
        .rd_data1 (rd_next)
    );

    assign in__ready  = ready_q;
    assign loaded     = loaded_q;
    // A partially (re)written table is never visible to the interpolator.
    assign base       = loaded_q ? rd_base : '0;
    assign next__data = loaded_q ? rd_next : '0;

`ifdef ACT_LUT_CHECKSUM_EN
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_act_lut_loader.sv
// Randomized scoreboard bench for act_lut_loader.
// The driver updates a table-level reference model and queues expected
// outputs; a negedge monitor pops and compares whenever a probe is raised.
module tb_act_lut_loader;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic signed [7:0] in__data = '0;
    logic              in__valid = 1'b0;
    logic              in__ready;
    logic              loaded;
    logic              error;
    logic [3:0]        address = '0;
    logic signed [7:0] base;
    logic signed [7:0] next__data;

    act_lut_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in__data   (in__data),
        .in__valid  (in__valid),
        .in__ready  (in__ready),
        .loaded     (loaded),
        .error      (error),
        .address    (address),
        .base       (base),
        .next__data (next__data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rdy;
        logic       ld;
        logic       er;
        logic [7:0] b;
        logic [7:0] n;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    bit   probe = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the committed table plus the words of the load in flight.
    logic [7:0] m_tbl[17];
    logic [7:0] m_words[$];
    bit         m_loading;
    bit         m_loaded;
    bit         m_err;
    logic [7:0] w[17];

    task automatic model_reset();
        foreach (m_tbl[i]) m_tbl[i] = 8'h00;
        m_words.delete();
        m_loading = 1'b0;
        m_loaded  = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic model_start();
        m_words.delete();
        m_loading = 1'b1;
        m_loaded  = 1'b0;
        m_err     = 1'b0;
    endtask

    task automatic model_accept(input logic [7:0] d);
        m_words.push_back(d);
`ifdef ACT_LUT_CHECKSUM_EN
        if (m_words.size() == 18) begin
            int s;
            s = 0;
            for (int i = 0; i < 17; i++) s += int'(m_words[i]);
            m_loading = 1'b0;
            if ((s % 256) == int'(d)) begin
                for (int i = 0; i < 17; i++) m_tbl[i] = m_words[i];
                m_loaded = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
`else
        if (m_words.size() == 17) begin
            for (int i = 0; i < 17; i++) m_tbl[i] = m_words[i];
            m_loaded  = 1'b1;
            m_loading = 1'b0;
        end
`endif
    endtask

    // Monitor: compares the DUT outputs against the oldest expectation.
    always @(negedge clk) begin
        if (probe) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL orphan_probe: got a probe with no queued expectation, want one");
            end else begin
                mon_e = exp_q.pop_front();
                if ({in__ready, loaded, error, base, next__data} !==
                    {mon_e.rdy, mon_e.ld, mon_e.er, mon_e.b, mon_e.n}) begin
                    n_bad++;
                    $display("FAIL %s addr=%0d: got rdy=%b loaded=%b err=%b base=%h next=%h, want rdy=%b loaded=%b err=%b base=%h next=%h",
                             mon_e.name, address, in__ready, loaded, error, base, next__data,
                             mon_e.rdy, mon_e.ld, mon_e.er, mon_e.b, mon_e.n);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Queue the model's view for one address and hold a probe for one cycle.
    task automatic check(input string nm, input logic [3:0] a);
        exp_t e;
        address = a;
        e.name  = nm;
        e.rdy   = m_loading;
        e.ld    = m_loaded;
        e.er    = m_err;
        e.b     = m_loaded ? m_tbl[int'(a)] : 8'h00;
        e.n     = m_loaded ? m_tbl[int'(a) + 1] : 8'h00;
        exp_q.push_back(e);
        probe = 1'b1;
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic sweep(input string nm);
        for (int a = 0; a < 16; a++) check(nm, 4'(a));
    endtask

    // Optional concurrent word exercises start-over-handshake priority.
    task automatic do_start(input bit with_word, input logic [7:0] d);
        in__valid = with_word;
        in__data  = d;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        in__valid = 1'b0;
        model_start();
    endtask

    task automatic send_word(input logic [7:0] d);
        int  t;
        bit  ok;
        t  = 0;
        ok = 1'b0;
        in__valid = 1'b1;
        in__data  = d;
        while (!ok && t <= 50) begin
            @(negedge clk);
            if (in__ready) ok = 1'b1;
            else t++;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        in__valid = 1'b0;
        if (ok) begin
            model_accept(d);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL handshake_timeout: got in__ready=0 for 50 cycles, want 1");
        end
    endtask

    // mode 0: gap-free, 1: idle probe after every word, 2: random gaps.
    task automatic run_load(input logic [7:0] words[17], input int mode);
        for (int i = 0; i < 17; i++) begin
            send_word(words[i]);
            if (mode == 1) check("gap_probe", 4'(i));
            else if (mode == 2 && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
`ifdef ACT_LUT_CHECKSUM_EN
        begin
            int s;
            s = 0;
            for (int i = 0; i < 17; i++) s += int'(words[i]);
            send_word(8'(s));
        end
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        idle(2);
        check("reset", 4'd3);
        rst = 1'b1;
        idle(1);
        check("preload", 4'd3);

        // Valid with no start: nothing accepted.
        in__valid = 1'b1;
        in__data  = 8'h55;
        for (int i = 0; i < 3; i++) check("valid_no_start", 4'(i));
        in__valid = 1'b0;

        // Ramp -8..8, gap-free.
        do_start(1'b0, 8'h00);
        check("rdy_after_start", 4'd0);
        for (int i = 0; i < 17; i++) w[i] = 8'(i - 8);
        run_load(w, 0);
        check("ramp_a0", 4'd0);
        check("ramp_a15", 4'd15);
        sweep("ramp");

        // Valid asserted while loaded: ignored, table unchanged.
        in__valid = 1'b1;
        in__data  = 8'h11;
        check("done_valid", 4'd7);
        in__valid = 1'b0;

        // Toggling valid with random data.
        do_start(1'b0, 8'h00);
        for (int i = 0; i < 17; i++) w[i] = 8'($urandom);
        run_load(w, 1);
        sweep("toggle");

        // Abort after 5 words; restart coincides with an offered word.
        do_start(1'b0, 8'h00);
        for (int i = 0; i < 5; i++) send_word(8'($urandom));
        check("abort_mid", 4'd2);
        do_start(1'b1, 8'h33);
        for (int i = 0; i < 17; i++) w[i] = 8'h7F;
        run_load(w, 1);
        sweep("abort_reload");

        // Reset in the middle of a load.
        do_start(1'b0, 8'h00);
        for (int i = 0; i < 10; i++) send_word(8'($urandom));
        rst = 1'b0;
        model_reset();
        check("rst_mid_a0", 4'd0);
        check("rst_mid_a15", 4'd15);
        rst = 1'b1;
        idle(1);
        check("after_rst", 4'd5);
        do_start(1'b0, 8'h00);
        for (int i = 0; i < 17; i++) w[i] = 8'($urandom);
        run_load(w, 2);
        sweep("rst_reload");

`ifdef ACT_LUT_CHECKSUM_EN
        // Seventeen ones: checksum 17 accepted, 16 rejected.
        do_start(1'b0, 8'h00);
        for (int i = 0; i < 17; i++) w[i] = 8'h01;
        run_load(w, 0);
        check("ck_good", 4'd4);
        do_start(1'b0, 8'h00);
        for (int i = 0; i < 17; i++) send_word(8'h01);
        send_word(8'd16);
        check("ck_bad", 4'd4);
        do_start(1'b0, 8'h00);
        check("ck_err_cleared", 4'd4);
`endif

        // Random loads with random gaps and random read addresses.
        for (int r = 0; r < 4; r++) begin
            do_start(1'($urandom_range(0, 1)), 8'($urandom));
            for (int i = 0; i < 17; i++) w[i] = 8'($urandom);
            run_load(w, 2);
            for (int k = 0; k < 6; k++) check("rand_read", 4'($urandom_range(0, 15)));
        end

        idle(2);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
